disp7seg_ctrl: RTL and testbench



---
 rtl/disp7seg_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_disp7seg_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/disp7seg_ctrl.sv
// ---------------------------------------------------------------------------
// disp7seg_ctrl
//
// Sequencer and shared write-port arbiter for the 8-digit multiplexed
// seven-segment display scanner.
//   * Prescaler: divides clockscan into a single-cycle scan-advance strobe
//     (clkenable), one pulse every SCAN_DIV cycles.
//   * Register bank: 8 entries of {4-bit nibble, decimal-point bit}. It
//     drives the scanner's d7..d0 / dp7..dp0 inputs.
//   * Arbiter: two requesters share the bank write port. A three-state FSM
//     (IDLE / ACK0 / ACK1) grants them in round-robin order with a
//     req/ack handshake.
//
// Optional feature macro: DISP_BLINK_EN
//   When it is defined, a blink phase bit toggles every BLINK_DIV clkenable
//   pulses. While the phase is 1, dps[i] is forced to 0 wherever
//   blink[i] = 1. The stored dp bits are never modified.
//   When it is undefined, dps shows the stored dp bits and blink is ignored.
//
// Parameters
//   SCAN_DIV  : clockscan cycles per clkenable pulse (>= 2)
//   BLINK_DIV : clkenable pulses per blink half-period (DISP_BLINK_EN only)
//
// Ports
//   clockscan     in   1   system clock
//   areset        in   1   asynchronous reset, active high
//   req0 / req1   in   1   write request from requester 0 / 1
//   addr0 / addr1 in   3   target digit index (0 = d0 .. 7 = d7)
//   data0 / data1 in   4   hex nibble to store
//   dpin0 / dpin1 in   1   decimal-point bit to store (1 = lit)
//   blink         in   8   per-digit dp blink mask
//   ack0 / ack1   out  1   one-cycle write-complete strobe
//   clkenable     out  1   scan-advance strobe to the scanner
//   digits        out  32  packed nibbles; [4i+3:4i] = digit i
//   dps           out  8   decimal points; bit i = digit i
// ---------------------------------------------------------------------------
module disp7seg_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 256
) (
    input  logic        clockscan,
    input  logic        areset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  addr0,
    input  logic [2:0]  addr1,
    input  logic [3:0]  data0,
    input  logic [3:0]  data1,
    input  logic        dpin0,
    input  logic        dpin1,
    input  logic [7:0]  blink,
    output logic        ack0,
    output logic        ack1,
    output logic        clkenable,
    output logic [31:0] digits,
    output logic [7:0]  dps
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SCAN_PRE  = CNT_W'(SCAN_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Arbiter FSM encoding. The value 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ACK0 = 2'b01;
    localparam logic [1:0] ST_ACK1 = 2'b10;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt_r;
    logic             clkenable_r;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             last_r;      // last-grant pointer: 0 = req0, 1 = req1
    logic             grant0_s;
    logic             grant1_s;
    logic             ack0_r;
    logic             ack1_r;

    logic             wr_en_s;
    logic [2:0]       wr_addr_s;
    logic [3:0]       wr_data_s;
    logic             wr_dp_s;

    logic [31:0]      digits_r;
    logic [7:0]       dp_r;

    // -----------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------
    // The strobe is registered: it is raised on the edge where the counter
    // steps to SCAN_LAST, so it is high exactly while the counter holds that
    // value. The output therefore has no combinational decode glitches.
    // Prescaler counter and registered scan strobe.
    always_ff @(posedge clockscan or posedge areset) begin
        if (areset) begin
            scan_cnt_r  <= '0;
            clkenable_r <= 1'b0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r  <= '0;
            clkenable_r <= 1'b0;
        end else begin
            scan_cnt_r  <= scan_cnt_r + CNT_ONE;
            clkenable_r <= (scan_cnt_r == SCAN_PRE);
        end
    end

    assign clkenable = clkenable_r;

    // -----------------------------------------------------------------------
    // Arbiter
    // -----------------------------------------------------------------------
    // Grants are only decided in IDLE. On a tie, the requester that does not
    // hold the last-grant pointer wins. This makes sustained contention
    // alternate between the two requesters.
    // Grant decision and next-state logic.
    always_comb begin
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    if (last_r) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end else if (req0) begin
                    grant0_s = 1'b1;
                end else if (req1) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end

                if (grant0_s) begin
                    state_nxt_s = ST_ACK0;
                end else if (grant1_s) begin
                    state_nxt_s = ST_ACK1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK0: state_nxt_s = ST_IDLE;
            ST_ACK1: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Write-port multiplexer: selects the granted requester's payload.
    always_comb begin
        wr_en_s = grant0_s | grant1_s;
        if (grant1_s) begin
            wr_addr_s = addr1;
            wr_data_s = data1;
            wr_dp_s   = dpin1;
        end else begin
            wr_addr_s = addr0;
            wr_data_s = data0;
            wr_dp_s   = dpin0;
        end
    end

    // FSM state, last-grant pointer and registered ack strobes.
    always_ff @(posedge clockscan or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;    // requester 0 wins the first tie
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ack0_r  <= grant0_s;
            ack1_r  <= grant1_s;
            if (grant0_s) begin
                last_r <= 1'b0;
            end else if (grant1_s) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
        end
    end

    assign ack0 = ack0_r;
    assign ack1 = ack1_r;

    // -----------------------------------------------------------------------
    // Register bank
    // -----------------------------------------------------------------------
    // The bank is written on the same edge as the grant, so ack and the new
    // contents appear together. Entries other than the granted address keep
    // their values.
    // Digit / decimal-point register bank.
    always_ff @(posedge clockscan or posedge areset) begin
        if (areset) begin
            digits_r <= 32'h0000_0000;
            dp_r     <= 8'h00;
        end else if (wr_en_s) begin
            digits_r[{wr_addr_s, 2'b00} +: 4] <= wr_data_s;
            dp_r[wr_addr_s]                   <= wr_dp_s;
        end else begin
            digits_r <= digits_r;
            dp_r     <= dp_r;
        end
    end

    assign digits = digits_r;

    // -----------------------------------------------------------------------
    // Decimal-point output (optional blink)
    // -----------------------------------------------------------------------
`ifdef DISP_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_phase_r;

    // Blink phase: flips after every BLINK_DIV scan strobes.
    always_ff @(posedge clockscan or posedge areset) begin
        if (areset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (clkenable_r) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BLINK_ONE;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Masking happens only on the way out; the stored dp bits stay intact.
    assign dps = dp_r & ~(blink & {8{blink_phase_r}});
`else
    // blink and BLINK_DIV have no function in this build. They are reduced
    // into a sink signal that is never read.
    logic unused_blink_s;
    assign unused_blink_s = ^{blink, (BLINK_DIV > 0)};

    assign dps = dp_r;
`endif

endmodule

// File: tb/tb_disp7seg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp7seg_ctrl
//
// Directed, self-checking bench for disp7seg_ctrl, run with SCAN_DIV = 4 and
// BLINK_DIV = 2. Outputs are sampled 1 time unit after each rising clock
// edge. Inputs change at those same sample points or on falling edges.
// ---------------------------------------------------------------------------
module tb_disp7seg_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        clockscan = 1'b0;
    logic        areset    = 1'b1;
    logic        req0      = 1'b0;
    logic        req1      = 1'b0;
    logic [2:0]  addr0     = 3'd0;
    logic [2:0]  addr1     = 3'd0;
    logic [3:0]  data0     = 4'h0;
    logic [3:0]  data1     = 4'h0;
    logic        dpin0     = 1'b0;
    logic        dpin1     = 1'b0;
    logic [7:0]  blink;
    logic        ack0;
    logic        ack1;
    logic        clkenable;
    logic [31:0] digits;
    logic [7:0]  dps;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;   // rising edges since reset release
    int g0       = 0;
    int g1       = 0;

    disp7seg_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clockscan (clockscan),
        .areset    (areset),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .data0     (data0),
        .data1     (data1),
        .dpin0     (dpin0),
        .dpin1     (dpin1),
        .blink     (blink),
        .ack0      (ack0),
        .ack1      (ack1),
        .clkenable (clkenable),
        .digits    (digits),
        .dps       (dps)
    );

    always #5 clockscan = ~clockscan;

    always @(posedge clockscan or posedge areset) begin
        if (areset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic tick;
        @(posedge clockscan);
        #1;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        @(negedge clockscan);
        @(negedge clockscan);
        areset = 1'b0;
    endtask

    initial begin
`ifdef DISP_BLINK_EN
        blink = 8'h00;
`else
        blink = 8'hFF;
`endif
        // ---- reset state ----------------------------------------------
        @(negedge clockscan);
        @(negedge clockscan);
        check("rst_ack0",      {31'd0, ack0},      32'd0);
        check("rst_ack1",      {31'd0, ack1},      32'd0);
        check("rst_clkenable", {31'd0, clkenable}, 32'd0);
        check("rst_digits",    digits,             32'h0000_0000);
        check("rst_dps",       {24'd0, dps},       32'h0000_0000);
        areset = 1'b0;

        // ---- prescaler: pulse while counter == 3 (cycles 4, 8, 12, 16) -
        for (int n = 1; n <= 20; n++) begin
            tick();
            check("clkenable", {31'd0, clkenable}, {31'd0, ((n % SCAN_DIV) == SCAN_DIV - 1)});
        end

        // ---- single write: req0, addr 5 = A, dp lit --------------------
        req0 = 1'b1; addr0 = 3'd5; data0 = 4'hA; dpin0 = 1'b1;
        tick();
        check("single_ack0",   {31'd0, ack0}, 32'd1);
        check("single_ack1",   {31'd0, ack1}, 32'd0);
        check("single_digits", digits,        32'h00A0_0000);
        check("single_dps",    {24'd0, dps},  32'h0000_0020);
        req0 = 1'b0;
        tick();
        check("single_ack0_fall", {31'd0, ack0}, 32'd0);
        check("single_hold",      digits,        32'h00A0_0000);

        // ---- same address: req1 addr2 = 3, then req0 addr2 = 7 ---------
        req1 = 1'b1; addr1 = 3'd2; data1 = 4'h3; dpin1 = 1'b0;
        tick();
        check("same_ack1",    {31'd0, ack1}, 32'd1);
        check("same_digits1", digits,        32'h00A0_0300);
        req1 = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 3'd2; data0 = 4'h7; dpin0 = 1'b1;
        tick();
        check("same_ack0",    {31'd0, ack0}, 32'd1);
        check("same_digits2", digits,        32'h00A0_0700);
        check("same_dps",     {24'd0, dps},  32'h0000_0024);
        req0 = 1'b0;
        tick();

        // ---- contention: both requesters, 6 grants 0,1,0,1,0,1 ---------
        do_reset();
        g0 = 0; g1 = 0;
        req0 = 1'b1; addr0 = 3'd0; data0 = 4'h1; dpin0 = 1'b1;
        req1 = 1'b1; addr1 = 3'd4; data1 = 4'h9; dpin1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("cont_ack0", {31'd0, ack0}, {31'd0, (i % 4) == 0});
            check("cont_ack1", {31'd0, ack1}, {31'd0, (i % 4) == 2});
            if (ack0) begin
                req0 = 1'b0;
                g0++;
            end else if (!req0 && g0 < 3) begin
                req0 = 1'b1; addr0 = 3'(g0); data0 = 4'(g0 + 1);
            end
            if (ack1) begin
                req1 = 1'b0;
                g1++;
            end else if (!req1 && g1 < 3) begin
                req1 = 1'b1; addr1 = 3'(4 + g1); data1 = 4'(9 + g1);
            end
        end
        check("cont_digits", digits,       32'h0BA9_0321);
        check("cont_dps",    {24'd0, dps}, 32'h0000_0007);

        // ---- reset in the ack0 cycle ----------------------------------
        req0 = 1'b1; addr0 = 3'd3; data0 = 4'hF; dpin0 = 1'b1;
        tick();
        check("mid_ack0_pre", {31'd0, ack0}, 32'd1);
        areset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b1; addr1 = 3'd6; data1 = 4'hC; dpin1 = 1'b1;
        #1;
        check("mid_ack0_rst", {31'd0, ack0}, 32'd0);
        check("mid_digits",   digits,        32'h0000_0000);
        check("mid_dps",      {24'd0, dps},  32'h0000_0000);
        @(negedge clockscan);
        areset = 1'b0;
        tick();
        check("mid_ack1",    {31'd0, ack1}, 32'd1);
        check("mid_digits1", digits,        32'h0C00_0000);
        check("mid_dps1",    {24'd0, dps},  32'h0000_0040);
        req1 = 1'b0;
        tick();
        check("mid_ack1_fall", {31'd0, ack1}, 32'd0);

`ifdef DISP_BLINK_EN
        // ---- blink: all dps lit, mask 81, phase flips every 8 cycles ---
        do_reset();
        blink = 8'h81;
        for (int a = 0; a < 8; a++) begin
            req0 = 1'b1; addr0 = 3'(a); data0 = 4'h0; dpin0 = 1'b1;
            tick();
            req0 = 1'b0;
            tick();
        end
        for (int c = 0; c < 24; c++) begin
            tick();
            check("blink_dps", {24'd0, dps},
                  (((edge_n / SCAN_DIV) / BLINK_DIV) % 2 == 1) ? 32'h7E : 32'hFF);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
